// File: rtl/jedec_p.sv
// Shared eMMC protocol definitions: response types, frame lengths and the
// CRC7 polynomial with a one-bit update step used by the CMD-line engine.
package jedec_p;

    typedef enum logic [2:0] {
        RESP_NONE = 3'd0,
        RESP_R1   = 3'd1,
        RESP_R1B  = 3'd2,
        RESP_R2   = 3'd3,
        RESP_R3   = 3'd4
    } resp_type_e;

    localparam int          CMD_FRAME_LEN = 48;
    localparam int          R2_FRAME_LEN  = 136;
    localparam logic [6:0]  CRC7_POLY     = 7'h09;  // x^7 + x^3 + 1

    // One serial CRC7 step, data bits presented MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/emmc_crc7.sv
// Serial CRC7 accumulator. clr restarts the remainder from zero; when clr and
// en are both high the presented bit is the first bit of a new CRC.
module emmc_crc7
    import jedec_p::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] base;

    assign base = clr_i ? 7'h00 : crc_o;

    // Remainder register: restart and/or absorb one bit per enabled cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_o <= 7'h00;
        end else if (en_i) begin
            crc_o <= crc7_step(base, bit_i);
        end else if (clr_i) begin
            crc_o <= 7'h00;
        end
    end

endmodule

// File: rtl/emmc_cmd_engine.sv
// eMMC CMD-line engine: sends a 48-bit command with CRC7, collects the
// NONE/R1/R1b/R2/R3 response, checks CRC/index/end bit, handles NCR and
// busy timeouts and holds the line idle for NCC_MIN cycles afterwards.
module emmc_cmd_engine
    import jedec_p::*;
#(
    parameter int NCR_MAX  = 64,
    parameter int NCC_MIN  = 8,
    parameter int BUSY_MAX = 65535,
    parameter int BUSY_W   = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [5:0]   cmd_idx_i,
    input  logic [31:0]  arg_i,
    input  logic [2:0]   resp_type_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [127:0] resp_o,
    output logic         crc_err_o,
    output logic         idx_err_o,
    output logic         tout_err_o,
    input  logic         emmc_cmd_i,
    output logic         emmc_cmd_o,
    output logic         emmc_cmd_oe_o,
    input  logic         emmc_dat0_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TX   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RX   = 3'd3;
    localparam logic [2:0] S_BUSY = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;

    localparam int              NCR_W     = $clog2(NCR_MAX + 1);
    localparam logic [NCR_W-1:0]  NCR_LAST  = NCR_W'(NCR_MAX - 1);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_MAX - 1);
    localparam logic [7:0]        NCC_LAST  = 8'(NCC_MIN - 1);
    localparam logic [7:0]        TX_CRC_AT = 8'd40;   // bits 47..8 precede the CRC
    localparam logic [7:0]        TX_DONE   = 8'(CMD_FRAME_LEN);

    logic [2:0]        state_q;
    logic [7:0]        bit_cnt_q;
    logic [NCR_W-1:0]  ncr_cnt_q;
    logic [BUSY_W-1:0] busy_cnt_q;
    // Serves as the TX data shifter and the RX shifter (never active together).
    // Only the last 127 received bits matter: the R2 header byte is never reported.
    logic [126:0]      shift_q;
    logic [5:0]        idx_q;
    resp_type_e        type_q;

    logic [127:0]      frame_next;
    logic [7:0]        rx_last;
    logic              accept;
    logic              crc_clr;
    logic              crc_en;
    logic              crc_bit;
    logic [6:0]        crc;

    assign accept     = start_i && ready_o && (state_q == S_IDLE);
    assign frame_next = {shift_q, emmc_cmd_i};
    assign rx_last    = (type_q == RESP_R2) ? 8'(R2_FRAME_LEN - 1) : 8'(CMD_FRAME_LEN - 1);

    // Route the shared CRC engine to whichever direction is active.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        crc_bit = 1'b0;
        case (state_q)
            S_IDLE: begin
                crc_clr = accept;
                crc_en  = accept;         // start bit of the command
            end
            S_TX: begin
                crc_en  = (bit_cnt_q < TX_CRC_AT);
                crc_bit = shift_q[38];
            end
            S_WAIT: begin
                crc_clr = !emmc_cmd_i;    // response start bit restarts the CRC
                crc_en  = !emmc_cmd_i && (type_q != RESP_R2);
            end
            S_RX: begin
                crc_bit = emmc_cmd_i;
                if (type_q == RESP_R2)
                    crc_en = (bit_cnt_q >= 8'd8) && (bit_cnt_q < 8'd128);
                else
                    crc_en = (bit_cnt_q < TX_CRC_AT);
            end
            default: ;
        endcase
    end

    emmc_crc7 u_crc7 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (crc_bit),
        .crc_o (crc)
    );

    // Main sequencer: command serialisation, response capture, checks and gaps.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every register
        // sees the pre-edge values of the others, independent of statement order.
        done_o <= 1'b0;
        if (rst_i) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= 8'd0;
            ncr_cnt_q     <= '0;
            busy_cnt_q    <= '0;
            shift_q       <= '0;
            idx_q         <= 6'd0;
            type_q        <= RESP_NONE;
            ready_o       <= 1'b1;
            done_o        <= 1'b0;
            resp_o        <= '0;
            crc_err_o     <= 1'b0;
            idx_err_o     <= 1'b0;
            tout_err_o    <= 1'b0;
            emmc_cmd_o    <= 1'b1;
            emmc_cmd_oe_o <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        idx_q         <= cmd_idx_i;
                        type_q        <= resp_type_e'(resp_type_i);
                        resp_o        <= '0;
                        crc_err_o     <= 1'b0;
                        idx_err_o     <= 1'b0;
                        tout_err_o    <= 1'b0;
                        ready_o       <= 1'b0;
                        emmc_cmd_o    <= 1'b0;          // start bit
                        emmc_cmd_oe_o <= 1'b1;
                        shift_q[38:0] <= {1'b1, cmd_idx_i, arg_i};
                        bit_cnt_q     <= 8'd1;
                        state_q       <= S_TX;
                    end
                end
                S_TX: begin
                    if (bit_cnt_q == TX_DONE) begin
                        emmc_cmd_o    <= 1'b1;
                        emmc_cmd_oe_o <= 1'b0;
                        if (type_q == RESP_NONE) begin
                            done_o    <= 1'b1;
                            bit_cnt_q <= 8'd0;
                            state_q   <= S_GAP;
                        end else begin
                            ncr_cnt_q <= '0;
                            state_q   <= S_WAIT;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                        if (bit_cnt_q == TX_CRC_AT) begin
                            // CRC is final now; queue its low bits and the end bit.
                            emmc_cmd_o     <= crc[6];
                            shift_q[38:32] <= {crc[5:0], 1'b1};
                        end else begin
                            emmc_cmd_o <= shift_q[38];
                            shift_q    <= {shift_q[125:0], 1'b0};
                        end
                    end
                end
                S_WAIT: begin
                    if (!emmc_cmd_i) begin
                        shift_q   <= frame_next[126:0];
                        bit_cnt_q <= 8'd1;
                        state_q   <= S_RX;
                    end else if (ncr_cnt_q == NCR_LAST) begin
                        tout_err_o <= 1'b1;
                        done_o     <= 1'b1;
                        bit_cnt_q  <= 8'd0;
                        state_q    <= S_GAP;
                    end else begin
                        ncr_cnt_q <= ncr_cnt_q + 1'b1;
                    end
                end
                S_RX: begin
                    shift_q <= frame_next[126:0];
                    if (bit_cnt_q == rx_last) begin
                        if (type_q == RESP_R2) begin
                            resp_o    <= {frame_next[127:1], 1'b0};
                            crc_err_o <= (frame_next[7:1] != crc) || !frame_next[0];
                        end else if (type_q == RESP_R3) begin
                            resp_o    <= {96'd0, frame_next[39:8]};
                            crc_err_o <= !frame_next[0];
                        end else begin
                            resp_o    <= {96'd0, frame_next[39:8]};
                            crc_err_o <= (frame_next[7:1] != crc) || !frame_next[0];
                            idx_err_o <= (frame_next[45:40] != idx_q);
                        end
                        if (type_q == RESP_R1B) begin
                            busy_cnt_q <= '0;
                            state_q    <= S_BUSY;
                        end else begin
                            done_o    <= 1'b1;
                            bit_cnt_q <= 8'd0;
                            state_q   <= S_GAP;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                    end
                end
                S_BUSY: begin
                    if (emmc_dat0_i) begin
                        done_o    <= 1'b1;
                        bit_cnt_q <= 8'd0;
                        state_q   <= S_GAP;
                    end else if (busy_cnt_q == BUSY_LAST) begin
                        tout_err_o <= 1'b1;
                        done_o     <= 1'b1;
                        bit_cnt_q  <= 8'd0;
                        state_q    <= S_GAP;
                    end else begin
                        busy_cnt_q <= busy_cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (bit_cnt_q == NCC_LAST) begin
                        ready_o <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                    end
                end
                default: begin
                    emmc_cmd_o    <= 1'b1;
                    emmc_cmd_oe_o <= 1'b0;
                    ready_o       <= 1'b1;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emmc_cmd_engine.sv
// Scoreboard bench for emmc_cmd_engine: stimulus pushes expected responses,
// a monitor pops and compares them whenever done_o pulses.
module tb_emmc_cmd_engine;
    import jedec_p::*;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [5:0]   cmd_idx_i = 6'd0;
    logic [31:0]  arg_i = 32'd0;
    logic [2:0]   resp_type_i = 3'd0;
    logic         ready_o;
    logic         done_o;
    logic [127:0] resp_o;
    logic         crc_err_o;
    logic         idx_err_o;
    logic         tout_err_o;
    logic         emmc_cmd_i = 1'b1;
    logic         emmc_cmd_o;
    logic         emmc_cmd_oe_o;
    logic         emmc_dat0_i = 1'b1;

    always #5 clk_i = ~clk_i;

    emmc_cmd_engine #(
        .NCR_MAX (64),
        .NCC_MIN (8),
        .BUSY_MAX(65535),
        .BUSY_W  (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .cmd_idx_i    (cmd_idx_i),
        .arg_i        (arg_i),
        .resp_type_i  (resp_type_i),
        .ready_o      (ready_o),
        .done_o       (done_o),
        .resp_o       (resp_o),
        .crc_err_o    (crc_err_o),
        .idx_err_o    (idx_err_o),
        .tout_err_o   (tout_err_o),
        .emmc_cmd_i   (emmc_cmd_i),
        .emmc_cmd_o   (emmc_cmd_o),
        .emmc_cmd_oe_o(emmc_cmd_oe_o),
        .emmc_dat0_i  (emmc_dat0_i)
    );

    typedef struct {
        string        name;
        logic [127:0] resp;
        logic         crc_err;
        logic         idx_err;
        logic         tout_err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7_bits(input logic [127:0] d, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_frame(input logic dir, input logic [5:0] idx, input logic [31:0] val);
        logic [39:0] h;
        h = {1'b0, dir, idx, val};
        return {h, crc7_bits({88'd0, h}, 40), 1'b1};
    endfunction

    function automatic exp_t mk_exp(input string name, input logic [127:0] resp,
                                    input logic ce, input logic ie, input logic te);
        exp_t e;
        e.name = name; e.resp = resp; e.crc_err = ce; e.idx_err = ie; e.tout_err = te;
        return e;
    endfunction

    // Monitor: every done_o pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (!rst_i && done_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 expected no completion");
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_resp"}, resp_o, mon_e.resp);
                check({mon_e.name, "_crc_err"}, 128'(crc_err_o), 128'(mon_e.crc_err));
                check({mon_e.name, "_idx_err"}, 128'(idx_err_o), 128'(mon_e.idx_err));
                check({mon_e.name, "_tout_err"}, 128'(tout_err_o), 128'(mon_e.tout_err));
            end
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_ready"}, 128'(ready_o), 128'(1));
    endtask

    // Issue one command and capture cycles 1..48; returns at the negedge of cycle 49.
    task automatic send_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                            input resp_type_e rt, output logic [47:0] frame, output int oe_cnt);
        wait_ready(name);
        start_i = 1'b1; cmd_idx_i = idx; arg_i = arg; resp_type_i = 3'(rt);
        @(negedge clk_i);
        start_i = 1'b0;
        oe_cnt = 0;
        for (int i = 47; i >= 0; i--) begin
            frame[i] = emmc_cmd_o;
            if (emmc_cmd_oe_o) oe_cnt++;
            @(negedge clk_i);
        end
    endtask

    task automatic drive_reply(input logic [135:0] bits, input int len, input int delay);
        repeat (delay) @(negedge clk_i);
        for (int i = len - 1; i >= 0; i--) begin
            emmc_cmd_i = bits[i];
            @(negedge clk_i);
        end
        emmc_cmd_i = 1'b1;
    endtask

    task automatic count_to_done(output int n);
        n = 0;
        while (!done_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic count_to_ready(output int n);
        n = 0;
        while (!ready_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got no end of test expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0]  frame;
        logic [47:0]  r1;
        logic [119:0] cid;
        logic [6:0]   cid_crc;
        logic [31:0]  ocr;
        int           oe_cnt;
        int           n;

        // Reset values
        repeat (3) @(negedge clk_i);
        check("rst_ready", 128'(ready_o), 128'(1));
        check("rst_done", 128'(done_o), 128'(0));
        check("rst_resp", resp_o, 128'(0));
        check("rst_errs", 128'({crc_err_o, idx_err_o, tout_err_o}), 128'(0));
        check("rst_cmd_o", 128'(emmc_cmd_o), 128'(1));
        check("rst_oe", 128'(emmc_cmd_oe_o), 128'(0));
        rst_i = 1'b0;
        @(negedge clk_i);

        // CMD0, no response
        exp_q.push_back(mk_exp("cmd0", 128'd0, 1'b0, 1'b0, 1'b0));
        send_cmd("cmd0", 6'd0, 32'd0, RESP_NONE, frame, oe_cnt);
        check("cmd0_frame", 128'(frame), 128'(48'h40_0000_0000_95));
        check("cmd0_oe_cycles", 128'(oe_cnt), 128'(48));
        check("cmd0_oe_off", 128'(emmc_cmd_oe_o), 128'(0));
        check("cmd0_done_cycle49", 128'(done_o), 128'(1));
        count_to_ready(n);
        check("cmd0_ncc_gap", 128'(n), 128'(8));

        // CMD17 R1, good reply 5 cycles after the command
        r1 = mk_frame(1'b0, 6'd17, 32'h0000_0900);
        exp_q.push_back(mk_exp("cmd17_ok", 128'h900, 1'b0, 1'b0, 1'b0));
        send_cmd("cmd17_ok", 6'd17, 32'd0, RESP_R1, frame, oe_cnt);
        check("cmd17_frame", 128'(frame), 128'(48'h51_0000_0000_55));
        drive_reply(136'(r1), 48, 5);
        check("cmd17_ok_done", 128'(done_o), 128'(1));

        // CMD17 R1 with one CRC bit flipped
        exp_q.push_back(mk_exp("cmd17_crc", 128'h900, 1'b1, 1'b0, 1'b0));
        send_cmd("cmd17_crc", 6'd17, 32'd0, RESP_R1, frame, oe_cnt);
        drive_reply(136'(r1 ^ 48'h2), 48, 5);

        // CMD17 R1 answered with index 0x12
        exp_q.push_back(mk_exp("cmd17_idx", 128'h900, 1'b0, 1'b1, 1'b0));
        send_cmd("cmd17_idx", 6'd17, 32'd0, RESP_R1, frame, oe_cnt);
        drive_reply(136'(mk_frame(1'b0, 6'h12, 32'h0000_0900)), 48, 5);

        // CMD17 R1, no reply: NCR timeout
        exp_q.push_back(mk_exp("cmd17_tout", 128'd0, 1'b0, 1'b0, 1'b1));
        send_cmd("cmd17_tout", 6'd17, 32'd0, RESP_R1, frame, oe_cnt);
        count_to_done(n);
        check("cmd17_ncr_cycles", 128'(n), 128'(64));
        @(negedge clk_i);
        count_to_ready(n);
        check("cmd17_tout_ncc", 128'(n + 1), 128'(8));

        // CMD1 R3: OCR with all-ones CRC field and index
        ocr = 32'hC0FF_8080;
        exp_q.push_back(mk_exp("cmd1_r3", 128'(ocr), 1'b0, 1'b0, 1'b0));
        send_cmd("cmd1_r3", 6'd1, 32'h40FF_8080, RESP_R3, frame, oe_cnt);
        check("cmd1_frame", 128'(frame), 128'(mk_frame(1'b1, 6'd1, 32'h40FF_8080)));
        drive_reply(136'({2'b00, 6'h3F, ocr, 7'h7F, 1'b1}), 48, 3);

        // CMD2 R2: CID body with model CRC
        cid     = 120'h1501_0053_454D_3332_4701_2345_6789_5E;
        cid_crc = crc7_bits({8'd0, cid}, 120);
        exp_q.push_back(mk_exp("cmd2_r2", {cid, cid_crc, 1'b0}, 1'b0, 1'b0, 1'b0));
        send_cmd("cmd2_r2", 6'd2, 32'd0, RESP_R2, frame, oe_cnt);
        check("cmd2_frame", 128'(frame), 128'(48'h42_0000_0000_4D));
        drive_reply({2'b00, 6'h3F, cid, cid_crc, 1'b1}, 136, 2);
        check("cmd2_done", 128'(done_o), 128'(1));

        // CMD6 R1b, DAT0 low for 100 cycles
        exp_q.push_back(mk_exp("cmd6_busy", 128'h800, 1'b0, 1'b0, 1'b0));
        send_cmd("cmd6_busy", 6'd6, 32'h03B7_0100, RESP_R1B, frame, oe_cnt);
        emmc_dat0_i = 1'b0;
        drive_reply(136'(mk_frame(1'b0, 6'd6, 32'h0000_0800)), 48, 4);
        check("cmd6_no_early_done", 128'(done_o), 128'(0));
        repeat (99) @(negedge clk_i);
        emmc_dat0_i = 1'b1;
        count_to_done(n);
        check("cmd6_done_after_dat0", 128'(n), 128'(1));

        // CMD6 R1b with DAT0 already high: immediate exit
        exp_q.push_back(mk_exp("cmd6_nobusy", 128'h900, 1'b0, 1'b0, 1'b0));
        send_cmd("cmd6_nobusy", 6'd6, 32'h03B7_0100, RESP_R1B, frame, oe_cnt);
        drive_reply(136'(mk_frame(1'b0, 6'd6, 32'h0000_0900)), 48, 4);
        count_to_done(n);
        check("cmd6_nobusy_done", 128'(n), 128'(1));

        // Reset pulsed mid-TX: idle values, no completion afterwards
        wait_ready("rst_mid");
        start_i = 1'b1; cmd_idx_i = 6'd17; arg_i = 32'h1234_5678; resp_type_i = 3'(RESP_R1);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("rst_mid_oe_before", 128'(emmc_cmd_oe_o), 128'(1));
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_ready", 128'(ready_o), 128'(1));
        check("rst_mid_oe", 128'(emmc_cmd_oe_o), 128'(0));
        check("rst_mid_cmd_o", 128'(emmc_cmd_o), 128'(1));
        check("rst_mid_resp", resp_o, 128'(0));
        check("rst_mid_done", 128'(done_o), 128'(0));
        rst_i = 1'b0;
        repeat (80) @(negedge clk_i);

        // Recovery after reset
        exp_q.push_back(mk_exp("cmd0_again", 128'd0, 1'b0, 1'b0, 1'b0));
        send_cmd("cmd0_again", 6'd0, 32'd0, RESP_NONE, frame, oe_cnt);
        check("cmd0_again_frame", 128'(frame), 128'(48'h40_0000_0000_95));
        count_to_ready(n);

        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
